freq_mul_pn: RTL and testbench
==============================

# freq_mul_pn

Parametrised successor to the single-factor frequency multiplier. The block measures the period of a slow input clock `infreq` in reference-clock cycles and generates `outfreq` at 2^n times the input frequency. Compared with the fixed 8-bit version it adds:

- configurable counter width;
- a 2-flop input synchroniser;
- measurement restart;
- an error flag for measurements that overflow or are too fast to synthesise.

It sits between the sample-clock input pin and downstream logic that needs a multiplied clock-enable.

## Interface
- `CW`, default 16: width of the period counter, the half-period timer and `k`.
- `NW`, default 3: width of the multiplier exponent `n`.

Ports:
- `clk`  in  1  reference clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the next `clk` edge).
- `infreq`  in  1  asynchronous input clock to be multiplied.
- `adjust`  in  1  level. While high, the block is held in arming; its falling edge starts a measurement.
- `n`  in  NW  exponent. The multiplication factor is 2^n; `n` is sampled in LOAD only.
- `outfreq`  out  1  multiplied output, a registered 50% square wave.
- `valid`  out  1  high while `outfreq` is being generated (RUN state).
- `k`  out  CW  last measured input period P, in `clk` cycles.
- `err`  out  1  sticky; the last measurement failed.

## Operation
- Synchroniser: `infreq` passes through `s1`→`s2`, and `s3` holds the previous `s2`. rise = `s2` & ~`s3`. Edge detection lags the pin by 2–3 cycles. P is unaffected by this lag because both edges see the same delay.
- States: IDLE, ARMED, SYNC, MEASURE, LOAD, RUN.
- IDLE:
  - adjust=1 → ARMED.
- ARMED:
  - clears `err`.
  - adjust=0 → SYNC.
- SYNC:
  - on rise: `cnt`←1, → MEASURE.
  - adjust=1 → ARMED (takes priority).
- MEASURE:
  - `cnt`←`cnt`+1 each cycle.
  - on rise: P←`cnt`, → LOAD.
  - adjust=1 → ARMED (priority over rise).
  - `cnt`=all-ones with no rise: `err`←1, → IDLE (no wrap-around).
- LOAD (one cycle):
  - `k`←P.
  - latch `n`.
  - H = P >> (n+1), computed in CW bits; a shift ≥ CW gives 0.
  - If H=0: `err`←1, → IDLE.
  - Otherwise: `tmr`←H−1, `outfreq`←0, → RUN.
- RUN:
  - `valid`=1.
  - If `tmr`=0: toggle `outfreq` and reload `tmr`←H−1.
  - Otherwise `tmr`←`tmr`−1.
  - adjust=1 → ARMED.
- Outside RUN, `outfreq` is forced to 0 on the next edge.
- The output period is 2·H cycles. This equals P/2^n exactly when 2^(n+1) divides P; otherwise the period is truncated. No averaging or dithering.
- Changes to `n` during RUN have no effect until the next adjust cycle.
- `k` holds its value across re-adjust and only updates in LOAD, including a LOAD that errors.

## Timing
- Reset values: state=IDLE, `outfreq`=0, `valid`=0, `k`=0, `err`=0. `cnt`, `tmr` and the synchroniser flops are 0.
- Reset mid-operation: all of the above apply on the next edge; no partial state survives.
- `valid` is a registered decode of the state:
  - it rises on the first RUN cycle;
  - it falls the cycle after adjust=1 is sampled in RUN.
- First `outfreq` toggle (0→1) occurs H cycles after entering RUN.
- Latency from the second detected rise to `valid`=1 is 2 cycles: the MEASURE→LOAD edge, then the LOAD→RUN edge.
- `err` sets on the edge leaving MEASURE or LOAD.
- Simultaneous events:
  - adjust=1 beats rise in SYNC/MEASURE.
  - Saturation with rise in the same cycle: rise wins and P = all-ones.
- `infreq` high or low times below 2 `clk` cycles are outside the contract. Edges may be missed.

## Test plan
1. CW=16, `infreq` period 64 `clk`, n=2:
   - pulse adjust 3 cycles; after the second synchronised rise, `k`=64 and `valid`=1 two cycles later;
   - `outfreq` toggles every 8 cycles (period 16); `err`=0.
2. Same stimulus, n=0 → H=32, `outfreq` period 64.
   - Then n=5 with P=40 → H=0: `err`=1, `valid`=0, state IDLE, `k`=40.
3. CW=8, `infreq` period 300 → `cnt` saturates at 255: `err`=1, `valid`=0, `outfreq`=0, `k` unchanged.
4. Re-adjust in RUN:
   - assert adjust → `valid`=0 and `outfreq`=0 next cycle;
   - change `infreq` period to 128 with n=3 → `k`=128, H=8.
   - Also assert adjust mid-MEASURE: measurement restarts and `k` is not updated.
5. Drive `rst`=0 for one cycle in MEASURE and again in RUN → all outputs at reset values on the next edge. The block stays IDLE until adjust.
6. `infreq` period 100, n=2 → H=12, `outfreq` period 24 (truncation), `k`=100. Changing `n` during RUN has no effect.

Source files
------------

// File: rtl/freq_mul_pn.sv
// -----------------------------------------------------------------------------
// freq_mul_pn
// Measures the period P of a slow asynchronous input clock in reference-clock
// cycles, then generates a registered 50% square wave at 2^n times the input
// frequency. The half period is H = P >> (n+1), so the output period is 2*H
// cycles, truncated when 2^(n+1) does not divide P.
//
// Parameters:
//   CW  width of the period counter, half-period timer and k
//   NW  width of the multiplier exponent n
// Ports:
//   clk      in   reference clock, rising edge
//   rst      in   synchronous active-low reset
//   infreq   in   asynchronous input clock to be multiplied
//   adjust   in   level; high holds the block armed, falling edge starts a
//                 measurement
//   n        in   exponent of the multiplication factor, sampled in LOAD
//   outfreq  out  multiplied square wave (registered)
//   valid    out  high while outfreq is being generated
//   k        out  last measured input period, in clk cycles
//   err      out  sticky flag: last measurement overflowed or was too fast
// -----------------------------------------------------------------------------
module freq_mul_pn #(
    parameter int CW = 16,
    parameter int NW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          infreq,
    input  logic          adjust,
    input  logic [NW-1:0] n,
    output logic          outfreq,
    output logic          valid,
    output logic [CW-1:0] k,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_SYNC    = 3'd2,
        S_MEASURE = 3'd3,
        S_LOAD    = 3'd4,
        S_RUN     = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_half;
    logic [CW-1:0] r_tmr;

    logic          w_rise;
    logic          w_cnt_full;
    logic [NW:0]   w_shamt;
    logic [CW-1:0] w_half;

    // Rising edge of the synchronised input; both period edges share the lag.
    assign w_rise     = r_s2 & ~r_s3;
    assign w_cnt_full = (r_cnt == {CW{1'b1}});
    // n+1 needs one extra bit so that n = all-ones does not wrap to zero.
    assign w_shamt    = {1'b0, n} + {{NW{1'b0}}, 1'b1};

    // Half-period for the requested exponent; shifts of CW or more give zero.
    always_comb begin
        w_half = {CW{1'b0}};
        if (int'(w_shamt) >= CW) begin
            w_half = {CW{1'b0}};
        end else begin
            w_half = r_period >> w_shamt;
        end
    end

    // Two-flop synchroniser plus history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= infreq;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Control FSM: measurement, load and output generation, registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_period <= {CW{1'b0}};
            r_half   <= {CW{1'b0}};
            r_tmr    <= {CW{1'b0}};
            outfreq  <= 1'b0;
            valid    <= 1'b0;
            k        <= {CW{1'b0}};
            err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    outfreq <= 1'b0;
                    valid   <= 1'b0;
                    if (adjust) begin
                        r_state <= S_ARMED;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ARMED: begin
                    outfreq <= 1'b0;
                    valid   <= 1'b0;
                    err     <= 1'b0;
                    if (!adjust) begin
                        r_state <= S_SYNC;
                    end else begin
                        r_state <= S_ARMED;
                    end
                end
                S_SYNC: begin
                    outfreq <= 1'b0;
                    valid   <= 1'b0;
                    if (adjust) begin
                        r_state <= S_ARMED;
                    end else if (w_rise) begin
                        // The rise cycle itself is count 0; the next cycle is 1.
                        r_cnt   <= {{(CW-1){1'b0}}, 1'b1};
                        r_state <= S_MEASURE;
                    end else begin
                        r_state <= S_SYNC;
                    end
                end
                S_MEASURE: begin
                    outfreq <= 1'b0;
                    valid   <= 1'b0;
                    if (adjust) begin
                        r_state <= S_ARMED;
                    end else if (w_rise) begin
                        // A rise on the saturated count still gives P = all-ones.
                        r_period <= r_cnt;
                        r_state  <= S_LOAD;
                    end else if (w_cnt_full) begin
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                        r_state <= S_MEASURE;
                    end
                end
                S_LOAD: begin
                    k       <= r_period;
                    outfreq <= 1'b0;
                    if (w_half == {CW{1'b0}}) begin
                        err     <= 1'b1;
                        valid   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_half  <= w_half;
                        r_tmr   <= w_half - {{(CW-1){1'b0}}, 1'b1};
                        valid   <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (adjust) begin
                        outfreq <= 1'b0;
                        valid   <= 1'b0;
                        r_state <= S_ARMED;
                    end else begin
                        valid   <= 1'b1;
                        r_state <= S_RUN;
                        if (r_tmr == {CW{1'b0}}) begin
                            outfreq <= ~outfreq;
                            r_tmr   <= r_half - {{(CW-1){1'b0}}, 1'b1};
                        end else begin
                            r_tmr   <= r_tmr - {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    outfreq <= 1'b0;
                    valid   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_mul_pn.sv
// -----------------------------------------------------------------------------
// tb_freq_mul_pn
// Self-checking bench for freq_mul_pn. A 16-bit instance covers the main
// function; an 8-bit instance covers counter saturation. Expected values come
// from the period/exponent arithmetic: k = P, H = P >> (n+1), err when H = 0
// or P exceeds the counter range, output toggles every H cycles.
// -----------------------------------------------------------------------------
module tb_freq_mul_pn;

    logic        clk = 1'b0;
    logic        rst;
    logic        infreq;
    logic        adjust;
    logic        adjust8;
    logic [2:0]  n;
    logic [2:0]  n8;
    logic        outfreq;
    logic        valid;
    logic        err;
    logic [15:0] k;
    logic        outfreq8;
    logic        valid8;
    logic        err8;
    logic [7:0]  k8;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int per = 64;
    int rise_cyc = 0;

    freq_mul_pn #(.CW(16), .NW(3)) dut (
        .clk(clk), .rst(rst), .infreq(infreq), .adjust(adjust), .n(n),
        .outfreq(outfreq), .valid(valid), .k(k), .err(err)
    );

    freq_mul_pn #(.CW(8), .NW(3)) dut8 (
        .clk(clk), .rst(rst), .infreq(infreq), .adjust(adjust8), .n(n8),
        .outfreq(outfreq8), .valid(valid8), .k(k8), .err(err8)
    );

    always #5 clk = ~clk;

    // Posedge counter used as the bench time base.
    always @(posedge clk) cyc <= cyc + 1;

    // Input clock generator: period 'per' clk cycles, edges on the falling edge.
    initial begin
        infreq = 1'b0;
        forever begin
            repeat (per - per / 2) @(negedge clk);
            infreq   = 1'b1;
            rise_cyc = cyc;
            repeat (per / 2) @(negedge clk);
            infreq = 1'b0;
        end
    end

    function automatic int model_half(input int p, input int nn, input int cw);
        if (nn + 1 >= cw) return 0;
        return p >> (nn + 1);
    endfunction

    task automatic pulse_adjust(input int hold, input int nn);
        n = nn[2:0];
        adjust = 1'b1;
        repeat (hold) @(negedge clk);
        adjust = 1'b0;
    endtask

    task automatic wait_pin_rise();
        int r0;
        int t;
        r0 = rise_cyc;
        t = 0;
        while (rise_cyc == r0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (rise_cyc == r0) begin
            fails++;
            $display("FAIL pin_rise_timeout: waited %0d cycles, required a pin rise", t);
        end
    endtask

    // Waits for the measurement result of the 16-bit instance and checks it.
    task automatic run_check(input string name, input int p, input int nn,
                             input bit chk_lat, input int n_mid);
        int h;
        bit exp_err;
        int t;
        int last;
        int tog;
        logic prev;
        h = model_half(p, nn, 16);
        exp_err = (h == 0);
        t = 0;
        while (valid !== 1'b1 && err !== 1'b1 && t < 4 * p + 40) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (exp_err) begin
            if (err !== 1'b1 || valid !== 1'b0) begin
                fails++;
                $display("FAIL %s_done: err=%b valid=%b, required err=1 valid=0", name, err, valid);
            end
        end else begin
            if (valid !== 1'b1 || err !== 1'b0) begin
                fails++;
                $display("FAIL %s_done: valid=%b err=%b after %0d cycles, required valid=1 err=0",
                         name, valid, err, t);
            end
        end
        tests++;
        if (k !== p[15:0]) begin
            fails++;
            $display("FAIL %s_k: k=%0d, required %0d", name, k, p);
        end
        if (exp_err) begin
            tests++;
            if (outfreq !== 1'b0) begin
                fails++;
                $display("FAIL %s_out_err: outfreq=%b, required 0", name, outfreq);
            end
            return;
        end
        if (chk_lat) begin
            tests++;
            if (cyc - rise_cyc != 4) begin
                fails++;
                $display("FAIL %s_latency: %0d cycles from pin rise to valid, required 4",
                         name, cyc - rise_cyc);
            end
        end
        tests++;
        if (outfreq !== 1'b0) begin
            fails++;
            $display("FAIL %s_out_first: outfreq=%b on first RUN cycle, required 0", name, outfreq);
        end
        n = n_mid[2:0];
        last = cyc;
        prev = 1'b0;
        tog = 0;
        t = 0;
        while (tog < 4 && t < 5 * h + 10) begin
            @(negedge clk);
            t++;
            if (outfreq !== prev) begin
                tests++;
                if (cyc - last != h || valid !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_interval: toggle %0d after %0d cycles valid=%b, required %0d valid=1",
                             name, tog, cyc - last, valid, h);
                end
                last = cyc;
                prev = outfreq;
                tog++;
            end
        end
        tests++;
        if (tog < 4) begin
            fails++;
            $display("FAIL %s_toggles: saw %0d toggles, required 4", name, tog);
        end
    endtask

    task automatic check_reset_vals(input string name);
        tests++;
        if (valid !== 1'b0 || outfreq !== 1'b0 || k !== 16'd0 || err !== 1'b0 ||
            valid8 !== 1'b0 || outfreq8 !== 1'b0 || k8 !== 8'd0 || err8 !== 1'b0) begin
            fails++;
            $display("FAIL %s: valid=%b outfreq=%b k=%0d err=%b / valid8=%b outfreq8=%b k8=%0d err8=%b, required all 0",
                     name, valid, outfreq, k, err, valid8, outfreq8, k8, err8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        adjust = 1'b0;
        adjust8 = 1'b0;
        n = 3'd0;
        n8 = 3'd2;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pulse_adjust(3, 2);
        run_check("basic", 64, 2, 1'b1, 2);
    endtask

    task automatic test_n0_and_hzero();
        pulse_adjust(3, 0);
        run_check("n0", 64, 0, 1'b0, 0);
        per = 40;
        pulse_adjust(2 * 40 + 4, 5);
        run_check("hzero", 40, 5, 1'b0, 5);
        repeat (200) @(negedge clk);
        tests++;
        if (valid !== 1'b0 || err !== 1'b1 || k !== 16'd40) begin
            fails++;
            $display("FAIL hzero_idle: valid=%b err=%b k=%0d, required 0 1 40", valid, err, k);
        end
    endtask

    task automatic test_readjust();
        int t;
        per = 64;
        pulse_adjust(2 * 64 + 4, 1);
        run_check("ra_pre", 64, 1, 1'b0, 1);
        t = 0;
        while (outfreq !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        adjust = 1'b1;
        @(negedge clk);
        tests++;
        if (valid !== 1'b0 || outfreq !== 1'b0) begin
            fails++;
            $display("FAIL readjust_stop: valid=%b outfreq=%b, required 0 0", valid, outfreq);
        end
        per = 128;
        pulse_adjust(2 * 128 + 4, 3);
        run_check("ra_128", 128, 3, 1'b0, 3);
    endtask

    task automatic test_mid_measure();
        per = 96;
        pulse_adjust(2 * 96 + 4, 1);
        wait_pin_rise();
        repeat (20) @(negedge clk);
        tests++;
        if (k !== 16'd128 || valid !== 1'b0) begin
            fails++;
            $display("FAIL midmeas_hold: k=%0d valid=%b, required 128 0", k, valid);
        end
        pulse_adjust(3, 1);
        tests++;
        if (k !== 16'd128) begin
            fails++;
            $display("FAIL midmeas_k_kept: k=%0d, required 128", k);
        end
        run_check("midmeas", 96, 1, 1'b0, 1);
    endtask

    task automatic test_saturate();
        int t;
        per = 100;
        adjust8 = 1'b1;
        repeat (204) @(negedge clk);
        adjust8 = 1'b0;
        t = 0;
        while (valid8 !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (valid8 !== 1'b1 || k8 !== 8'd100 || err8 !== 1'b0) begin
            fails++;
            $display("FAIL sat_pre: valid8=%b k8=%0d err8=%b, required 1 100 0", valid8, k8, err8);
        end
        per = 300;
        adjust8 = 1'b1;
        repeat (604) @(negedge clk);
        adjust8 = 1'b0;
        t = 0;
        while (err8 !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (err8 !== 1'b1 || valid8 !== 1'b0 || outfreq8 !== 1'b0 || k8 !== 8'd100) begin
            fails++;
            $display("FAIL sat: err8=%b valid8=%b outfreq8=%b k8=%0d, required 1 0 0 100",
                     err8, valid8, outfreq8, k8);
        end
    endtask

    task automatic test_reset_midop();
        per = 64;
        pulse_adjust(2 * 64 + 4, 2);
        wait_pin_rise();
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_measure");
        rst = 1'b1;
        repeat (200) @(negedge clk);
        tests++;
        if (valid !== 1'b0 || k !== 16'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL rst_stay_idle: valid=%b k=%0d err=%b, required 0 0 0", valid, k, err);
        end
        pulse_adjust(3, 2);
        run_check("rst_run", 64, 2, 1'b0, 2);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_in_run");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_truncation();
        per = 100;
        pulse_adjust(2 * 100 + 4, 2);
        run_check("trunc", 100, 2, 1'b0, 7);
    endtask

    task automatic test_random();
        int p;
        int nn;
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(400, 40);
            nn = $urandom_range(7, 0);
            per = p;
            pulse_adjust(2 * p + 4, nn);
            run_check("rand", p, nn, 1'b1, $urandom_range(7, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_n0_and_hzero();
        test_readjust();
        test_mid_measure();
        test_saturate();
        test_reset_midop();
        test_truncation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
